// File: rtl/ex_mem_skid_pkg.sv
// Shared types and constants for the EX/MEM pipeline boundary of the xgriscv core.
// The entry struct is the bundle stored in the skid buffer between EX and MEM.
package ex_mem_skid_pkg;

  localparam int XLEN = 32;
  localparam int EXMEM_W = 3*XLEN + 5 + 3 + 4;

  localparam logic [2:0] FUNCT3_B = 3'b000;
  localparam logic [2:0] FUNCT3_H = 3'b001;
  localparam logic [2:0] FUNCT3_W = 3'b010;

  typedef struct packed {
    logic [XLEN-1:0] aluout;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] storedata;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            misalign;
  } exmem_entry_t;

  // Size is funct3[1:0]; the sign bit does not affect alignment.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    logic m;
    m = 1'b0;
    if (funct3[1:0] == FUNCT3_B[1:0])
      m = 1'b0;
    else if (funct3[1:0] == FUNCT3_H[1:0])
      m = addr[0];
    else if (funct3[1:0] == FUNCT3_W[1:0])
      m = |addr;
    return m;
  endfunction

endpackage

// File: rtl/ex_mem_skid_if.sv
// EX -> skid buffer -> MEM handshake bundle plus the fetch redirect.
// master = EX side and MEM consumer as seen by the driver; slave = the boundary block.
interface ex_mem_skid_if import ex_mem_skid_pkg::*;;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_aluout;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_btarget;
  logic            in_is_branch;
  logic            in_is_jump;
  logic [4:0]      in_rd;
  logic            in_regwrite;
  logic            in_memread;
  logic            in_memwrite;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_storedata;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_aluout;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_storedata;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic            out_regwrite;
  logic            out_memread;
  logic            out_memwrite;
  logic            out_misalign;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output in_valid, in_aluout, in_pc, in_btarget, in_is_branch, in_is_jump, in_rd,
           in_regwrite, in_memread, in_memwrite, in_funct3, in_storedata, flush, out_ready,
    input  in_ready, out_valid, out_aluout, out_pc, out_storedata, out_rd, out_funct3,
           out_regwrite, out_memread, out_memwrite, out_misalign, redirect_valid, redirect_pc
  );

  modport slave (
    input  in_valid, in_aluout, in_pc, in_btarget, in_is_branch, in_is_jump, in_rd,
           in_regwrite, in_memread, in_memwrite, in_funct3, in_storedata, flush, out_ready,
    output in_ready, out_valid, out_aluout, out_pc, out_storedata, out_rd, out_funct3,
           out_regwrite, out_memread, out_memwrite, out_misalign, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ex_mem_skid_fifo2.sv
// Generic 2-entry valid/ready skid FIFO with synchronous flush.
// in_ready is registered so no combinational ready path crosses the boundary.
module skid_fifo2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH != 2) begin : g_depth_check
    $error("skid_fifo2 supports DEPTH = 2 only");
  end

  logic             head_valid;
  logic             tail_valid;
  logic [WIDTH-1:0] tail_data;
  logic             accept;
  logic             pop;
  logic [1:0]       count;
  logic [1:0]       count_next;

  assign out_valid = head_valid;
  assign accept    = in_valid & in_ready;
  assign pop       = head_valid & out_ready;

  always_comb begin
    count      = 2'(head_valid) + 2'(tail_valid);
    count_next = flush ? 2'd0 : count + 2'(accept) - 2'(pop);
  end

  // out_data is the head register itself, so it holds while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
      out_data   <= '0;
      tail_data  <= '0;
      in_ready   <= 1'b1;
    end else begin
      in_ready <= (count_next < 2'd2);
      if (flush) begin
        head_valid <= 1'b0;
        tail_valid <= 1'b0;
      end else if (tail_valid) begin
        if (pop) begin
          out_data   <= tail_data;
          tail_valid <= 1'b0;
        end
      end else if (head_valid) begin
        if (pop && accept) begin
          out_data <= in_data;
        end else if (pop) begin
          head_valid <= 1'b0;
        end else if (accept) begin
          tail_data  <= in_data;
          tail_valid <= 1'b1;
        end
      end else if (accept) begin
        out_data   <= in_data;
        head_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM boundary: packs EX results into skid-buffer entries, flags misaligned
// memory accesses and issues a one-cycle registered fetch redirect.
module ex_mem_skid import ex_mem_skid_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rstn,
  ex_mem_skid_if.slave  bus
);

  exmem_entry_t     in_entry;
  exmem_entry_t     out_entry;
  logic [EXMEM_W-1:0] out_bits;
  logic             accept;
  logic             taken;

  // Branches never write back or touch memory once resolved here.
  always_comb begin
    in_entry           = '0;
    in_entry.aluout    = bus.in_aluout;
    in_entry.pc        = bus.in_pc;
    in_entry.storedata = bus.in_storedata;
    in_entry.rd        = bus.in_rd;
    in_entry.funct3    = bus.in_funct3;
    in_entry.regwrite  = bus.in_regwrite & ~bus.in_is_branch;
    in_entry.memread   = bus.in_memread  & ~bus.in_is_branch;
    in_entry.memwrite  = bus.in_memwrite & ~bus.in_is_branch;
    in_entry.misalign  = (in_entry.memread | in_entry.memwrite)
                         & misaligned(bus.in_funct3, bus.in_aluout[1:0]);
  end

  skid_fifo2 #(
    .WIDTH (EXMEM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_bits)
  );

  assign out_entry         = exmem_entry_t'(out_bits);
  assign bus.out_aluout    = out_entry.aluout;
  assign bus.out_pc        = out_entry.pc;
  assign bus.out_storedata = out_entry.storedata;
  assign bus.out_rd        = out_entry.rd;
  assign bus.out_funct3    = out_entry.funct3;
  assign bus.out_regwrite  = out_entry.regwrite;
  assign bus.out_memread   = out_entry.memread;
  assign bus.out_memwrite  = out_entry.memwrite;
  assign bus.out_misalign  = out_entry.misalign;

  assign accept = bus.in_valid & bus.in_ready;
  assign taken  = bus.in_is_jump | (bus.in_is_branch & bus.in_aluout[0]);

  // Flush suppresses a new redirect but cannot recall one already on the wire.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else begin
      bus.redirect_valid <= accept & ~bus.flush & taken;
      if (accept && !bus.flush && taken)
        bus.redirect_pc <= bus.in_btarget;
    end
  end

endmodule
